// File: rtl/usb_pc_pkg.sv
// usb_pc_pkg: shared command bytes, response strings, FSM states and bus shift helper for usb_pc_bridge.
package usb_pc_pkg;
  localparam logic [7:0] ID_I = "I";
  localparam logic [7:0] ID_W = "W";
  localparam logic [7:0] ID_R = "R";
  localparam logic [2:0][7:0] SYNC_B = "CMD";
  localparam logic [2:0][7:0] CMP_B = "CMP";
  localparam logic [2:0][7:0] ERR_B = "ERR";
  typedef enum logic [3:0] {
    S_SYNC, S_CMD, S_PARAM, S_WDATA, S_WBUS, S_RREQ,
    S_RWAIT, S_RDATA, S_IDENT, S_RESP, S_WCSUM, S_RCSUM
  } state_e;
  function automatic int bus_shift(input int bus_bytes);
    return (bus_bytes == 4) ? 2 : 1;
  endfunction
endpackage

// File: rtl/usb_pc_timeout.sv
// usb_pc_timeout: loadable down-counter; expire_o flags CYCLES enabled clocks since the last clear.
module usb_pc_timeout #(
  parameter int CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire_o = en_i && cnt_q == '0;
  always_comb cnt_d = clear_i ? W'(CYCLES - 1) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usb_pc_bridge.sv
// usb_pc_bridge: FTDI byte-stream command engine (identify, burst write, burst read) for the cart bus.
// Define USB_PC_BRIDGE_CHECKSUM_EN to add a mod-256 data checksum byte to write and read frames.
module usb_pc_bridge
  import usb_pc_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W = 26,
  parameter int BANK_W = 4,
  parameter int LEN_W = 20,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] VERSION = "b"
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  output logic                   o_rx_ready,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_tx_busy,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_request,
  output logic                   o_write,
  input  logic                   i_busy,
  input  logic                   i_ack,
  output logic [BANK_W-1:0]      o_bank,
  output logic [ADDR_W-1:0]      o_address,
  output logic [8*BUS_BYTES-1:0] o_data,
  input  logic [8*BUS_BYTES-1:0] i_data,
  output logic                   o_busy,
  output logic                   o_error
);
  localparam int SH = bus_shift(BUS_BYTES);
  localparam int DW = 8 * BUS_BYTES;
  localparam int AW = ADDR_W - SH;
  localparam logic [3:0][7:0] IDENT_B = {"S64", VERSION};
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
  localparam state_e W_DONE = S_WCSUM, R_DONE = S_RCSUM;
`else
  localparam state_e W_DONE = S_RESP, R_DONE = S_RESP;
`endif
  state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] id_q, id_d, resp_b;
  logic err_q, err_d, error_q, error_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [7:0] sum_q;
  logic rx_fire, tx_fire, to_en, expire, sync_hit, known;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
  logic [7:0] sum_d;
`else
  assign sum_q = '0;
`endif
  assign o_rx_ready = state_q inside {S_SYNC, S_CMD, S_PARAM, S_WDATA, S_WCSUM};
  assign o_tx_valid = state_q inside {S_RDATA, S_IDENT, S_RESP, S_RCSUM};
  assign o_request = state_q inside {S_WBUS, S_RREQ};
  assign o_write = state_q == S_WBUS;
  assign o_busy = state_q != S_SYNC;
  assign o_error = error_q;
  assign o_bank = bank_q;
  assign o_address = addr_q;
  assign o_data = data_q;
  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tx_fire = o_tx_valid && !i_tx_busy;
  assign to_en = state_q inside {S_PARAM, S_WDATA, S_WCSUM};
  assign sync_hit = i_rx_data == SYNC_B[2'd2 - sync_q];
  assign known = i_rx_data inside {ID_I, ID_W, ID_R};
  assign resp_b = err_q ? ERR_B[2'd2 - cnt_q[1:0]] : CMP_B[2'd2 - cnt_q[1:0]];
  always_comb
    o_tx_data = state_q == S_RDATA ? data_q[DW-1 -: 8] :
                state_q == S_RCSUM ? sum_q :
                state_q == S_IDENT ? IDENT_B[2'd3 - cnt_q[1:0]] :
                cnt_q == 3'd3 ? id_q : resp_b;
  usb_pc_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i(i_clk), .rst_i(i_reset), .clear_i(!to_en || rx_fire), .en_i(to_en), .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    sync_d = sync_q;
    cnt_d = cnt_q;
    id_d = id_q;
    err_d = err_q;
    error_d = 1'b0;
    bank_d = bank_q;
    addr_d = addr_q;
    data_d = data_q;
    count_d = count_q;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
    sum_d = sum_q;
`endif
    // A byte landing in the expiry cycle is dropped: the abort takes priority.
    if (expire) begin
      state_d = S_RESP;
      err_d = 1'b1;
      error_d = 1'b1;
      cnt_d = '0;
    end else case (state_q)
      S_SYNC: if (rx_fire) begin
        sync_d = sync_hit ? sync_q + 2'd1 : {1'b0, i_rx_data == SYNC_B[2]};
        if (sync_hit && sync_q == 2'd2) begin
          state_d = S_CMD;
          sync_d = '0;
        end
      end
      S_CMD: if (rx_fire) begin
        id_d = i_rx_data;
        cnt_d = '0;
        err_d = !known;
        error_d = !known;
        state_d = i_rx_data == ID_I ? S_IDENT : known ? S_PARAM : S_RESP;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
        sum_d = '0;
`endif
      end
      S_PARAM: if (rx_fire) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd0) bank_d = i_rx_data[BANK_W-1:0];
        else if (cnt_q <= 3'd3) addr_d = {AW'({addr_q[ADDR_W-1:SH], i_rx_data}), {SH{1'b0}}};
        else count_d = LEN_W'({count_q, i_rx_data});
        if (cnt_q == 3'd7) state_d = id_q == ID_W ? S_WDATA : S_RREQ;
      end
      S_WDATA: if (rx_fire) begin
        data_d = {data_q[DW-9:0], i_rx_data};
        cnt_d = cnt_q + 3'd1;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
        sum_d = sum_q + i_rx_data;
`endif
        if (cnt_q == 3'(BUS_BYTES - 1)) begin
          state_d = S_WBUS;
          cnt_d = '0;
        end
      end
      S_WBUS: if (!i_busy) begin
        addr_d = addr_q + ADDR_W'(BUS_BYTES);
        count_d = count_q - LEN_W'(1);
        state_d = count_q != '0 ? S_WDATA : W_DONE;
      end
      S_WCSUM: if (rx_fire) begin
        state_d = S_RESP;
        err_d = i_rx_data != sum_q;
        error_d = i_rx_data != sum_q;
      end
      S_RREQ: if (!i_busy) state_d = S_RWAIT;
      S_RWAIT: if (i_ack) begin
        data_d = i_data;
        cnt_d = '0;
        state_d = S_RDATA;
      end
      S_RDATA: if (tx_fire) begin
        data_d = data_q << 8;
        cnt_d = cnt_q + 3'd1;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
        sum_d = sum_q + data_q[DW-1 -: 8];
`endif
        if (cnt_q == 3'(BUS_BYTES - 1)) begin
          cnt_d = '0;
          state_d = count_q == '0 ? R_DONE : S_RREQ;
          if (count_q != '0) begin
            addr_d = addr_q + ADDR_W'(BUS_BYTES);
            count_d = count_q - LEN_W'(1);
          end
        end
      end
      S_RCSUM: if (tx_fire) state_d = S_RESP;
      S_IDENT: if (tx_fire) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = S_RESP;
          cnt_d = '0;
        end
      end
      S_RESP: if (tx_fire) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = S_SYNC;
          cnt_d = '0;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_SYNC;
      sync_q <= '0;
      cnt_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
      error_q <= 1'b0;
      bank_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      count_q <= '0;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      err_q <= err_d;
      error_q <= error_d;
      bank_q <= bank_d;
      addr_q <= addr_d;
      data_q <= data_d;
      count_q <= count_d;
`ifdef USB_PC_BRIDGE_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule
